// File: rtl/display_scan_ctrl.sv
// Purpose: converts an 8-bit magnitude plus sign to BCD and scans it onto a 4-digit common-anode display.
// Latency: load at cycle N -> busy N+1..N+8, done and display buffer update at N+9; new content appears at the next slot boundary.
// Backpressure: load is ignored while busy; the scan free-runs and never stalls.
//
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   load, value, neg  capture strobe, unsigned magnitude, sign flag
//   busy, done        conversion in progress, one-cycle buffer-update pulse
//   digit, seg_en     BCD code and enable to the registered seven-segment decoder
//   minus             light segment g alone on the sign slot
//   an                active-low anode selects, an[0] = units
module display_scan_ctrl #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] value,
    input  logic       neg,
    output logic       busy,
    output logic       done,
    output logic [3:0] digit,
    output logic       seg_en,
    output logic       minus,
    output logic [3:0] an
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] P_LAST  = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] P_BLANK = PW'(BLANK_CYCLES);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t      state, state_nx;
    logic [7:0]  bin, bin_nx;
    logic [11:0] bcd, bcd_nx;
    logic [2:0]  cnt, cnt_nx;
    logic        sgn_cap, sgn_cap_nx;
    logic        upd;
    logic [11:0] adj;
    logic [19:0] sh;

    logic [11:0] disp_bcd;
    logic        disp_sgn;

    // Double dabble step: correct nibbles that would overflow past 9, then shift.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            adj[i*4 +: 4] = (bcd[i*4 +: 4] >= 4'd5) ? bcd[i*4 +: 4] + 4'd3 : bcd[i*4 +: 4];
        end
        sh = {adj, bin} << 1;
    end

    always_comb begin
        state_nx   = state;
        bin_nx     = bin;
        bcd_nx     = bcd;
        cnt_nx     = cnt;
        sgn_cap_nx = sgn_cap;
        upd        = 1'b0;
        case (state)
            IDLE: begin
                if (load) begin
                    bin_nx     = value;
                    bcd_nx     = 12'd0;
                    cnt_nx     = 3'd7;
                    // No "-0": a zero magnitude never shows the sign.
                    sgn_cap_nx = neg && (value != 8'd0);
                    state_nx   = SHIFT;
                end
            end
            SHIFT: begin
                bcd_nx = sh[19:8];
                bin_nx = sh[7:0];
                cnt_nx = cnt - 3'd1;
                if (cnt == 3'd0) begin
                    upd      = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            bin      <= 8'd0;
            bcd      <= 12'd0;
            cnt      <= 3'd0;
            sgn_cap  <= 1'b0;
            disp_bcd <= 12'd0;
            disp_sgn <= 1'b0;
            done     <= 1'b0;
        end else begin
            state   <= state_nx;
            bin     <= bin_nx;
            bcd     <= bcd_nx;
            cnt     <= cnt_nx;
            sgn_cap <= sgn_cap_nx;
            done    <= upd;
            // Buffer only moves on a completed conversion, never mid-shift.
            if (upd) begin
                disp_bcd <= sh[19:8];
                disp_sgn <= sgn_cap;
            end
        end
    end

    assign busy = (state == SHIFT);

    // ---------------- scan ----------------
    logic [PW-1:0] p;
    logic [1:0]    idx;
    logic          lit;
    logic          slot_on, slot_en, slot_minus;
    logic [3:0]    slot_dig;

    always_comb begin
        slot_on    = 1'b0;
        slot_en    = 1'b0;
        slot_minus = 1'b0;
        slot_dig   = 4'd0;
        case (idx)
            2'd0: begin
                slot_on  = 1'b1;
                slot_dig = disp_bcd[3:0];
            end
            2'd1: begin
                // Leading-zero suppression: tens blank only when hundreds is also zero.
                slot_on  = (disp_bcd[11:8] != 4'd0) || (disp_bcd[7:4] != 4'd0);
                slot_dig = slot_on ? disp_bcd[7:4] : 4'd0;
            end
            2'd2: begin
                slot_on  = (disp_bcd[11:8] != 4'd0);
                slot_dig = disp_bcd[11:8];
            end
            default: begin
                slot_on    = disp_sgn;
                slot_minus = disp_sgn;
            end
        endcase
        slot_en = slot_on && (idx != 2'd3);
    end

    // Decoder inputs are sampled once per slot at p==0 so the registered decoder
    // output has settled before the anodes turn on after the blanking window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p      <= '0;
            idx    <= 2'd0;
            digit  <= 4'd0;
            seg_en <= 1'b0;
            minus  <= 1'b0;
            lit    <= 1'b0;
        end else begin
            if (p == P_LAST) begin
                p   <= '0;
                idx <= idx + 2'd1;
            end else begin
                p <= p + 1'b1;
            end
            if (p == '0) begin
                digit  <= slot_dig;
                seg_en <= slot_en;
                minus  <= slot_minus;
                lit    <= slot_on;
            end
        end
    end

    assign an = ((p < P_BLANK) || !lit) ? 4'b1111 : ~(4'b0001 << idx);

endmodule
